// File: rtl/conv_pkg.sv
// Shared state encoding and default sizing for the streaming 2-D correlator.
package conv_pkg;

    localparam int DEF_DW     = 8;
    localparam int DEF_MAXDIM = 16;
    localparam int DEF_MAXK   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMG,
        LOAD_KER,
        COMPUTE,
        EMIT,
        DONE
    } conv_state_e;

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate; clr restarts the sum with the current product.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = 2*DW
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          en,
    input  logic          clr,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [AW-1:0] acc
);

    logic [2*DW-1:0] prod;
    logic [AW-1:0]   acc_q, acc_d;

    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = (clr ? '0 : acc_q) + AW'(prod);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 2-D cross-correlation: loads an image and kernel, then emits one
// valid/ready-handshaked sum per output window in row-major order.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int MAXDIM = DEF_MAXDIM,
    parameter int MAXK   = DEF_MAXK,
    parameter int DIMW   = $clog2(MAXDIM),
    parameter int KW     = $clog2(MAXK),
    parameter int AW     = 2*DW + 2*KW
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            start,
    input  logic [DIMW-1:0] inRow,
    input  logic [DIMW-1:0] inCol,
    input  logic [KW-1:0]   kerRow,
    input  logic [KW-1:0]   kerCol,
    input  logic            stride,
    input  logic [DW-1:0]   inData,
    input  logic            inValid,
    output logic            inReady,
    output logic [AW-1:0]   outMatrix,
    output logic            outValid,
    input  logic            outReady,
    output logic            busy,
    output logic            done,
    output logic            err
);

    conv_state_e     state_q, state_d;
    logic [DIMW-1:0] inRow_q, inRow_d, inCol_q, inCol_d;
    logic [KW-1:0]   kerRow_q, kerRow_d, kerCol_q, kerCol_d;
    logic            stride_q, stride_d;
    logic [DIMW-1:0] imgR_q, imgR_d, imgC_q, imgC_d;
    logic [KW-1:0]   kerR_q, kerR_d, kerC_q, kerC_d;
    logic [DIMW-1:0] outR_q, outR_d, outC_q, outC_d;
    logic [KW-1:0]   tapK_q, tapK_d, tapL_q, tapL_d;
    logic            err_q, err_d;

    logic [DW-1:0] imgBuf [MAXDIM][MAXDIM];
    logic [DW-1:0] kerBuf [MAXK][MAXK];

    logic            xfer, imgWe, kerWe, macEn, macClr;
    logic [DIMW-1:0] diffR, diffC, lastOutR, lastOutC;
    logic [DIMW-1:0] rowBase, colBase, rowIdx, colIdx;
    logic [DW-1:0]   macA, macB;
    logic [AW-1:0]   macAcc;

    assign xfer  = inValid && inReady;
    assign imgWe = xfer && (state_q == LOAD_IMG);
    assign kerWe = xfer && (state_q == LOAD_KER);

    // Index of the final output window; stride 2 halves the valid span.
    assign diffR    = inRow_q - DIMW'(kerRow_q);
    assign diffC    = inCol_q - DIMW'(kerCol_q);
    assign lastOutR = stride_q ? (diffR >> 1) : diffR;
    assign lastOutC = stride_q ? (diffC >> 1) : diffC;

    assign rowBase = stride_q ? {outR_q[DIMW-2:0], 1'b0} : outR_q;
    assign colBase = stride_q ? {outC_q[DIMW-2:0], 1'b0} : outC_q;
    assign rowIdx  = rowBase + DIMW'(tapK_q);
    assign colIdx  = colBase + DIMW'(tapL_q);
    assign macA    = imgBuf[rowIdx][colIdx];
    assign macB    = kerBuf[tapK_q][tapL_q];

    always_ff @(posedge clk) begin
        if (imgWe) begin
            imgBuf[imgR_q][imgC_q] <= inData;
        end
        if (kerWe) begin
            kerBuf[kerR_q][kerC_q] <= inData;
        end
    end

    always_comb begin
        state_d  = state_q;
        inRow_d  = inRow_q;
        inCol_d  = inCol_q;
        kerRow_d = kerRow_q;
        kerCol_d = kerCol_q;
        stride_d = stride_q;
        imgR_d   = imgR_q;
        imgC_d   = imgC_q;
        kerR_d   = kerR_q;
        kerC_d   = kerC_q;
        outR_d   = outR_q;
        outC_d   = outC_q;
        tapK_d   = tapK_q;
        tapL_d   = tapL_q;
        err_d    = 1'b0;
        macEn    = 1'b0;
        macClr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    inRow_d  = inRow;
                    inCol_d  = inCol;
                    kerRow_d = kerRow;
                    kerCol_d = kerCol;
                    stride_d = stride;
                    if ((int'(kerRow) > int'(inRow)) || (int'(kerCol) > int'(inCol))) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD_IMG;
                        imgR_d  = '0;
                        imgC_d  = '0;
                        kerR_d  = '0;
                        kerC_d  = '0;
                    end
                end
            end
            LOAD_IMG: begin
                if (inValid) begin
                    if (imgC_q == inCol_q) begin
                        imgC_d = '0;
                        if (imgR_q == inRow_q) begin
                            imgR_d  = '0;
                            state_d = LOAD_KER;
                        end else begin
                            imgR_d = imgR_q + 1'b1;
                        end
                    end else begin
                        imgC_d = imgC_q + 1'b1;
                    end
                end
            end
            LOAD_KER: begin
                if (inValid) begin
                    if (kerC_q == kerCol_q) begin
                        kerC_d = '0;
                        if (kerR_q == kerRow_q) begin
                            kerR_d  = '0;
                            outR_d  = '0;
                            outC_d  = '0;
                            tapK_d  = '0;
                            tapL_d  = '0;
                            state_d = COMPUTE;
                        end else begin
                            kerR_d = kerR_q + 1'b1;
                        end
                    end else begin
                        kerC_d = kerC_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                // First tap of every window restarts the accumulator.
                macEn  = 1'b1;
                macClr = (tapK_q == '0) && (tapL_q == '0);
                if (tapL_q == kerCol_q) begin
                    tapL_d = '0;
                    if (tapK_q == kerRow_q) begin
                        tapK_d  = '0;
                        state_d = EMIT;
                    end else begin
                        tapK_d = tapK_q + 1'b1;
                    end
                end else begin
                    tapL_d = tapL_q + 1'b1;
                end
            end
            EMIT: begin
                if (outReady) begin
                    state_d = COMPUTE;
                    if (outC_q == lastOutC) begin
                        outC_d = '0;
                        if (outR_q == lastOutR) begin
                            outR_d  = '0;
                            state_d = DONE;
                        end else begin
                            outR_d = outR_q + 1'b1;
                        end
                    end else begin
                        outC_d = outC_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= IDLE;
            inRow_q  <= '0;
            inCol_q  <= '0;
            kerRow_q <= '0;
            kerCol_q <= '0;
            stride_q <= 1'b0;
            imgR_q   <= '0;
            imgC_q   <= '0;
            kerR_q   <= '0;
            kerC_q   <= '0;
            outR_q   <= '0;
            outC_q   <= '0;
            tapK_q   <= '0;
            tapL_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inRow_q  <= inRow_d;
            inCol_q  <= inCol_d;
            kerRow_q <= kerRow_d;
            kerCol_q <= kerCol_d;
            stride_q <= stride_d;
            imgR_q   <= imgR_d;
            imgC_q   <= imgC_d;
            kerR_q   <= kerR_d;
            kerC_q   <= kerC_d;
            outR_q   <= outR_d;
            outC_q   <= outC_d;
            tapK_q   <= tapK_d;
            tapL_q   <= tapL_d;
            err_q    <= err_d;
        end
    end

    conv_mac #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk  (clk),
        .rstN (rstN),
        .en   (macEn),
        .clr  (macClr),
        .a    (macA),
        .b    (macB),
        .acc  (macAcc)
    );

    assign inReady   = (state_q == LOAD_IMG) || (state_q == LOAD_KER);
    assign outValid  = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign outMatrix = macAcc;

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream: table of jobs with hand-computed sums plus
// backpressure, illegal-dimension and mid-job reset sequences.
module tb_conv2d_stream;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [3:0]  inRow, inCol;
    logic [1:0]  kerRow, kerCol;
    logic        stride;
    logic [7:0]  inData;
    logic        inValid;
    logic        inReady;
    logic [19:0] outMatrix;
    logic        outValid;
    logic        outReady;
    logic        busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]       inRow;
        logic [3:0]       inCol;
        logic [1:0]       kerRow;
        logic [1:0]       kerCol;
        logic             stride;
        logic             imgConst;
        logic [7:0]       imgVal;
        logic [7:0]       kerVal;
        logic [2:0]       nOut;
        logic [3:0][31:0] expv;
    } job_t;

    job_t vec [5];

    conv2d_stream dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .inRow     (inRow),
        .inCol     (inCol),
        .kerRow    (kerRow),
        .kerCol    (kerCol),
        .stride    (stride),
        .inData    (inData),
        .inValid   (inValid),
        .inReady   (inReady),
        .outMatrix (outMatrix),
        .outValid  (outValid),
        .outReady  (outReady),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic job_t mkJob(input int r, input int c, input int kr, input int kc,
                                   input logic s, input logic ic, input int iv, input int kv,
                                   input int n, input int e0, input int e1, input int e2, input int e3);
        job_t j;
        j.inRow    = 4'(r);
        j.inCol    = 4'(c);
        j.kerRow   = 2'(kr);
        j.kerCol   = 2'(kc);
        j.stride   = s;
        j.imgConst = ic;
        j.imgVal   = 8'(iv);
        j.kerVal   = 8'(kv);
        j.nOut     = 3'(n);
        j.expv[0]  = 32'(e0);
        j.expv[1]  = 32'(e1);
        j.expv[2]  = 32'(e2);
        j.expv[3]  = 32'(e3);
        return j;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic sendElem(input logic [7:0] d);
        int guard = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = d;
        while (!inReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL inReady timeout: got 0, expected 1");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic applyStimulus(input job_t j);
        int nImg = (int'(j.inRow) + 1) * (int'(j.inCol) + 1);
        int nKer = (int'(j.kerRow) + 1) * (int'(j.kerCol) + 1);
        @(negedge clk);
        inRow  = j.inRow;
        inCol  = j.inCol;
        kerRow = j.kerRow;
        kerCol = j.kerCol;
        stride = j.stride;
        start  = 1'b1;
        @(posedge clk);
        #1;
        // Scramble the configuration inputs; the job must use the latched copy.
        start  = 1'b0;
        inRow  = 4'hF;
        inCol  = 4'hF;
        kerRow = 2'd0;
        kerCol = 2'd0;
        stride = ~j.stride;
        for (int i = 0; i < nImg; i++) begin
            sendElem(j.imgConst ? j.imgVal : 8'(i + 1));
        end
        for (int i = 0; i < nKer; i++) begin
            sendElem(j.kerVal);
        end
    endtask

    task automatic waitOutput(output bit ok);
        int guard = 0;
        @(negedge clk);
        while (!outValid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        ok = outValid;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL outValid timeout: got 0, expected 1");
        end
    endtask

    task automatic collectOutputs(input job_t j, input int idx, input bit hold);
        bit ok;
        bit stable;
        for (int k = 0; k < int'(j.nOut); k++) begin
            waitOutput(ok);
            if (!ok) return;
            checkOutput($sformatf("job%0d out%0d", idx, k), 64'(outMatrix), 64'(j.expv[k]));
            if (hold && k == 0) begin
                stable = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (!(outValid === 1'b1 && outMatrix === j.expv[k][19:0])) stable = 1'b0;
                end
                checkOutput("backpressure hold", 64'(stable), 64'd1);
            end
            outReady = 1'b1;
            @(posedge clk);
            #1;
            outReady = 1'b0;
        end
        @(negedge clk);
        checkOutput($sformatf("job%0d done pulse", idx), 64'(done), 64'd1);
        @(negedge clk);
        checkOutput($sformatf("job%0d back idle", idx), 64'({done, busy}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int errCnt;
        bit busySeen, rdySeen, outSeen;

        clk = 1'b0; rstN = 1'b0; start = 1'b0;
        inRow = '0; inCol = '0; kerRow = '0; kerCol = '0; stride = 1'b0;
        inData = '0; inValid = 1'b0; outReady = 1'b0;

        vec[0] = mkJob(2, 2, 1, 1, 1'b0, 1'b0, 0,   1,   4, 12, 16, 24, 28);
        vec[1] = mkJob(3, 3, 1, 1, 1'b1, 1'b0, 0,   1,   4, 14, 22, 46, 54);
        vec[2] = mkJob(3, 3, 3, 3, 1'b0, 1'b1, 255, 255, 1, 1040400, 0, 0, 0);
        vec[3] = mkJob(2, 2, 0, 0, 1'b1, 1'b0, 0,   2,   4, 2, 6, 14, 18);
        vec[4] = mkJob(1, 2, 1, 2, 1'b0, 1'b0, 0,   2,   1, 42, 0, 0, 0);

        #12;
        checkOutput("reset inReady",   64'(inReady),   64'd0);
        checkOutput("reset outValid",  64'(outValid),  64'd0);
        checkOutput("reset busy",      64'(busy),      64'd0);
        checkOutput("reset done",      64'(done),      64'd0);
        checkOutput("reset err",       64'(err),       64'd0);
        checkOutput("reset outMatrix", 64'(outMatrix), 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        for (int t = 0; t < 5; t++) begin
            applyStimulus(vec[t]);
            collectOutputs(vec[t], t, 1'b0);
        end

        // Sink stalls on the first result.
        applyStimulus(vec[0]);
        collectOutputs(vec[0], 10, 1'b1);

        // Kernel taller than the image.
        @(negedge clk);
        inRow = 4'd1; inCol = 4'd3; kerRow = 2'd2; kerCol = 2'd0; stride = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        errCnt = 0; busySeen = 1'b0; rdySeen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (err) errCnt++;
            if (busy) busySeen = 1'b1;
            if (inReady) rdySeen = 1'b1;
        end
        checkOutput("err pulse count", 64'(errCnt),   64'd1);
        checkOutput("err busy seen",   64'(busySeen), 64'd0);
        checkOutput("err inReady seen", 64'(rdySeen), 64'd0);

        // Asynchronous reset during the second window.
        applyStimulus(vec[0]);
        waitOutput(ok);
        checkOutput("rst job out0", 64'(outMatrix), 64'd12);
        outReady = 1'b1;
        @(posedge clk);
        #3;
        outReady = 1'b0;
        checkOutput("rst pre busy", 64'(busy), 64'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rst async outValid",  64'(outValid),  64'd0);
        checkOutput("rst async outMatrix", 64'(outMatrix), 64'd0);
        checkOutput("rst async busy",      64'(busy),      64'd0);
        checkOutput("rst async inReady",   64'(inReady),   64'd0);
        @(negedge clk);
        rstN = 1'b1;
        outSeen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (outValid || busy || done) outSeen = 1'b1;
        end
        checkOutput("rst no further output", 64'(outSeen), 64'd0);

        applyStimulus(vec[1]);
        collectOutputs(vec[1], 20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-002 Parameter DW, default 8, SHALL set the width of image and kernel elements (unsigned).
REQ-003 Parameter MAXDIM, default 16, SHALL set the largest image side; DIMW = $clog2(MAXDIM).
REQ-004 Parameter MAXK, default 4, SHALL set the largest kernel side; KW = $clog2(MAXK).
REQ-005 Parameter AW, default 2*DW+2*KW, SHALL set the accumulator and output width.
REQ-006 Ports SHALL be as follows:
- clk  in  1  rising-edge clock
- rstN  in  1  async active-low reset
- start  in  1  begin a job; sampled only in IDLE
- inRow  in  DIMW  image rows minus 1
- inCol  in  DIMW  image columns minus 1
- kerRow  in  KW  kernel rows minus 1
- kerCol  in  KW  kernel columns minus 1
- stride  in  1  0 = stride 1, 1 = stride 2
- inData  in  DW  streamed element
- inValid  in  1  inData valid
- inReady  out  1  block accepts inData
- outMatrix  out  AW  result element
- outValid  out  1  outMatrix valid
- outReady  in  1  sink accepts outMatrix
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the last output
- err  out  1  one-cycle pulse on an illegal dimension

Function
REQ-007 States SHALL be IDLE, LOAD_IMG, LOAD_KER, COMPUTE, EMIT and DONE.
REQ-008 In IDLE, start=1 SHALL latch inRow, inCol, kerRow, kerCol and stride; later changes to these inputs SHALL be ignored until the next IDLE.
REQ-009 If the latched kerRow>inRow or kerCol>inCol, the block SHALL pulse err for one cycle and stay in IDLE.
REQ-010 Otherwise the block SHALL enter LOAD_IMG.
REQ-011 In LOAD_IMG and LOAD_KER, inReady SHALL be 1; an element SHALL transfer only on a cycle with inValid and inReady both high.
REQ-012 Data SHALL arrive row-major: (inRow+1)*(inCol+1) image elements, then (kerRow+1)*(kerCol+1) kernel elements.
REQ-013 Elements SHALL be stored in an internal MAXDIM x MAXDIM image buffer and a MAXK x MAXK kernel buffer.
REQ-014 On the last image transfer the block SHALL go to LOAD_KER; on the last kernel transfer it SHALL go to COMPUTE.
REQ-015 The output shape SHALL be OR = (inRow-kerRow)/S + 1 rows by OC = (inCol-kerCol)/S + 1 columns, where S is 1 or 2 and the division is integer floor.
REQ-016 Each output SHALL be the unflipped cross-correlation: sum over (k,l) of img[r*S+k][c*S+l] * ker[k][l].
REQ-017 COMPUTE SHALL perform one multiply-accumulate per cycle, so each window takes exactly (kerRow+1)*(kerCol+1) cycles.
REQ-018 The accumulator SHALL be AW bits wide and SHALL clear at the start of each window; it cannot overflow under the default parameters.
REQ-019 After the last tap the block SHALL enter EMIT and assert outValid with the sum.
REQ-020 outMatrix and outValid SHALL hold stable until outReady=1.
REQ-021 On the outValid and outReady handshake, the block SHALL return to COMPUTE for the next window in row-major order, or go to DONE after window (OR-1, OC-1).
REQ-022 DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-023 inReady SHALL be 0 in COMPUTE, EMIT, DONE and IDLE.
REQ-024 start SHALL be ignored while busy=1.

Reset
REQ-025 When rstN=0, the block SHALL go to IDLE with all counters and the accumulator cleared.
REQ-026 When rstN=0, inReady, outValid, busy, done and err SHALL be 0, and outMatrix SHALL be 0.
REQ-027 Reset in any state, including mid-stream or mid-EMIT, SHALL abort the job with no further outputs.
REQ-028 Buffer contents need not be cleared on reset.

Structure
REQ-029 A shared package conv_pkg SHALL hold the state enumeration and the default DW, MAXDIM and MAXK constants.
REQ-030 A single sub-module conv_mac SHALL implement the registered DW x DW multiply and AW accumulate with a clear input.

Verification
REQ-031 3x3 image 1..9, 2x2 kernel of all 1s, stride 0 -> outputs 12, 16, 24, 28, then done.
REQ-032 4x4 image 1..16, 2x2 kernel of all 1s, stride 1 -> outputs 14, 22, 46, 54.
REQ-033 Hold outReady=0 for 10 cycles at the first EMIT -> outMatrix and outValid stay stable, and no data is lost afterward.
REQ-034 inRow=1, kerRow=2, start -> err pulses for one cycle, busy stays 0 and no inReady is seen.
REQ-035 4x4 image of all 255, 4x4 kernel of all 255 -> single output 1040400.
REQ-036 Drop rstN during the second COMPUTE window -> all outputs return to 0 asynchronously, and a fresh job then runs correctly.
